tik_sched: RTL and testbench

- Timestep scheduler for one node. Generates the `tik` strobe that drives every work controller in the node.
- The falling edge of `tik` starts an inference/code/clear sweep in each core. Each core reports activity on its `work_config_busy`.
- The block holds off the next `tik` until all cores are idle and the programmed period has elapsed.
- It counts steps, flags period overruns, and supports bounded or free-running operation plus graceful stop.

---
 rtl/node_pkg.sv | 30 +++
 rtl/tik_sched.sv | 133 +++++++++++++
 tb/tb_tik_sched.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/node_pkg.sv
// Node-wide shared types: scheduler state encodings, default guard depth, spike codes.
// No logic; imported by every block in the node.
// Purely declarative, so there is no latency or backpressure.
package node_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] TIK_HI = 3'd1;
  localparam logic [2:0] GUARD  = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = IDLE,
    ST_TIK_HI = TIK_HI,
    ST_GUARD  = GUARD,
    ST_WAIT   = WAIT,
    ST_DONE   = DONE
  } sched_state_t;

  // Covers the cores' 3-flop tik edge detect plus their state register.
  localparam int GUARD_DEF = 4;

  typedef enum logic [1:0] {
    SPK_NONE = 2'd0,
    SPK_EXC  = 2'd1,
    SPK_INH  = 2'd2,
    SPK_RST  = 2'd3
  } spike_code_t;

endpackage

// File: rtl/tik_sched.sv
// Timestep scheduler: issues tik once all cores are idle and the period has elapsed (optional TIK_SCHED_OVERRUN_CNT_EN).
// Latency: first tik rises 1 cycle after run_start; later tiks every eff_period cycles when cores keep up.
// Backpressure: any core_busy outside the guard window holds off the next tik; a late finish pulses overrun.
module tik_sched
  import node_pkg::*;
#(
  parameter int NCORE = 4,
  parameter int TW    = 16,
  parameter int SNW   = 16,
  parameter int HW    = 4,
  parameter int GUARD = GUARD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_start,
  input  logic             run_stop,
  input  logic [TW-1:0]    period,
  input  logic [SNW-1:0]   step_num,
  input  logic [HW-1:0]    tik_high,
  input  logic [NCORE-1:0] core_busy,
  output logic             tik,
  output logic [SNW-1:0]   step_cnt,
  output logic             sched_busy,
  output logic             run_done,
  output logic             overrun
`ifdef TIK_SCHED_OVERRUN_CNT_EN
  ,
  output logic [15:0]      overrun_cnt
`endif
);

  localparam int GW = $clog2(GUARD + 1);
  localparam int DW = (HW > GW) ? HW : GW;

  sched_state_t   state, state_nxt;
  logic [TW-1:0]  cfg_period;
  logic [SNW-1:0] cfg_steps;
  logic [HW-1:0]  cfg_hi;
  logic [HW-1:0]  hi_eff;
  logic [TW-1:0]  min_period;
  logic [TW-1:0]  eff_period;
  logic [TW-1:0]  pcnt;
  logic [DW-1:0]  dcnt;
  logic           stop_pend;
  logic           stop_req;
  logic           start_ok;
  logic           all_idle;
  logic           last_step;
  logic           tik_entry;

  assign hi_eff     = (cfg_hi == '0) ? HW'(1) : cfg_hi;
  assign min_period = TW'(hi_eff) + TW'(GUARD + 1);
  assign eff_period = (cfg_period > min_period) ? cfg_period : min_period;

  assign start_ok  = (state == ST_IDLE) && run_start;
  assign all_idle  = ~|core_busy;
  assign last_step = (cfg_steps != '0) && (step_cnt == cfg_steps);
  // A stop arriving in the deciding cycle must still suppress the next tik.
  assign stop_req  = stop_pend | run_stop;
  assign tik_entry = (state_nxt == ST_TIK_HI) && (state != ST_TIK_HI);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (run_start) state_nxt = ST_TIK_HI;
      ST_TIK_HI: if (dcnt == DW'(hi_eff) - DW'(1)) state_nxt = ST_GUARD;
      ST_GUARD:  if (dcnt == DW'(GUARD - 1)) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (all_idle) begin
          if (stop_req || last_step)            state_nxt = ST_DONE;
          else if (pcnt >= eff_period - TW'(1)) state_nxt = ST_TIK_HI;
        end
      end
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      tik        <= 1'b0;
      pcnt       <= '0;
      dcnt       <= '0;
      step_cnt   <= '0;
      stop_pend  <= 1'b0;
      cfg_period <= '0;
      cfg_steps  <= '0;
      cfg_hi     <= '0;
    end else begin
      state <= state_nxt;
      tik   <= (state_nxt == ST_TIK_HI);
      dcnt  <= (state_nxt != state) ? '0 : dcnt + DW'(1);

      if (tik_entry)
        pcnt <= '0;
      else if ((state != ST_IDLE) && (pcnt != '1))
        pcnt <= pcnt + TW'(1);

      if (tik_entry)
        step_cnt <= (state == ST_IDLE) ? SNW'(1) : step_cnt + SNW'(1);

      if (state == ST_DONE)
        stop_pend <= 1'b0;
      else if (run_stop && (state != ST_IDLE))
        stop_pend <= 1'b1;

      if (start_ok) begin
        cfg_period <= period;
        cfg_steps  <= step_num;
        cfg_hi     <= tik_high;
      end
    end
  end

  assign sched_busy = (state != ST_IDLE);
  assign run_done   = (state == ST_DONE);
  // Saturated pcnt can never equal eff_period-1, so at most one pulse per step.
  assign overrun    = (state != ST_IDLE) && (pcnt == eff_period - TW'(1)) &&
                      !((state == ST_WAIT) && all_idle);

`ifdef TIK_SCHED_OVERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      overrun_cnt <= '0;
    else if (start_ok)
      overrun_cnt <= '0;
    else if (overrun && (overrun_cnt != 16'hFFFF))
      overrun_cnt <= overrun_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_tik_sched.sv
// Scoreboard bench for tik_sched: expected tik edges, run_done and overrun cycles are queued per run.
// Event cycles are relative to the cycle in which run_start is driven.
module tb_tik_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run_start = 1'b0;
  logic        run_stop = 1'b0;
  logic [15:0] period = '0;
  logic [15:0] step_num = '0;
  logic [3:0]  tik_high = '0;
  logic [3:0]  core_busy = '0;
  logic        tik;
  logic [15:0] step_cnt;
  logic        sched_busy;
  logic        run_done;
  logic        overrun;
`ifdef TIK_SCHED_OVERRUN_CNT_EN
  logic [15:0] overrun_cnt;
`endif

  tik_sched #(
    .NCORE(4), .TW(16), .SNW(16), .HW(4), .GUARD(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_start  (run_start),
    .run_stop   (run_stop),
    .period     (period),
    .step_num   (step_num),
    .tik_high   (tik_high),
    .core_busy  (core_busy),
    .tik        (tik),
    .step_cnt   (step_cnt),
    .sched_busy (sched_busy),
    .run_done   (run_done),
    .overrun    (overrun)
`ifdef TIK_SCHED_OVERRUN_CNT_EN
    ,
    .overrun_cnt(overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          t0 = 0;
  int          tid = 0;
  int          errors = 0;
  int          checks = 0;
  logic        tik_prev = 1'b0;
  logic [31:0] expq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Event word: kind in the top byte (1 rise, 2 fall, 3 done, 4 overrun), relative cycle below.
  task automatic ex(input int kind, input int rel);
    logic [31:0] w;
    w = {kind[7:0], rel[23:0]};
    expq.push_back(w);
  endtask

  task automatic on_event(input int kind, input int rel);
    logic [31:0] got;
    got = {kind[7:0], rel[23:0]};
    if (expq.size() == 0) chk("evt_unexpected", got, 32'hFFFF_FFFF);
    else                  chk("evt", got, expq.pop_front());
  endtask

  function automatic logic busy_on(input int id, input int rel);
    case (id)
      1:       return ((rel >= 6)  && (rel <= 13)) || ((rel >= 26) && (rel <= 33)) ||
                      ((rel >= 46) && (rel <= 53));
      2:       return (rel >= 2)  && (rel <= 31);
      4:       return (rel >= 52) && (rel <= 69);
      default: return 1'b0;
    endcase
  endfunction

  task automatic start_run(input int id, input int p, input int sn, input int hi, input logic stop);
    @(posedge clk); #1;
    tid       = id;
    period    = 16'(p);
    step_num  = 16'(sn);
    tik_high  = 4'(hi);
    run_start = 1'b1;
    run_stop  = stop;
    core_busy = '0;
    t0        = cyc;
  endtask

  // Monitors outputs on the falling edge, drives inputs 1 unit after the rising edge.
  task automatic run_for(input int last);
    int rel;
    rel = 0;
    while (rel < last) begin
      @(negedge clk);
      rel = cyc - t0;
      if (tik && !tik_prev) on_event(1, rel);
      if (!tik && tik_prev) on_event(2, rel);
      if (run_done)         on_event(3, rel);
      if (overrun)          on_event(4, rel);
      tik_prev = tik;

      @(posedge clk); #1;
      rel       = cyc - t0;
      run_start = 1'b0;
      run_stop  = 1'b0;
      period    = 16'd3;
      step_num  = 16'd1;
      tik_high  = 4'd9;
      core_busy = busy_on(tid, rel) ? (4'b0001 << (rel % 4)) : 4'b0000;
      if (rel == 1) chk("sched_busy_in_run", 32'(sched_busy), 1);
      if (tid == 4 && rel == 55) run_stop = 1'b1;
      if (tid == 6 && rel == 5) begin
        run_start = 1'b1;
        period    = 16'd30;
        step_num  = 16'd1;
        tik_high  = 4'd5;
      end
      if (tid == 6 && rel == 6) chk("ignored_start_step_cnt", 32'(step_cnt), 1);
      if (tid == 5 && rel == 2) rst_n = 1'b0;
      if (tid == 5 && rel == 3) begin
        rst_n = 1'b1;
        chk("rst_mid_tik", 32'(tik), 0);
        chk("rst_mid_sched_busy", 32'(sched_busy), 0);
        chk("rst_mid_step_cnt", 32'(step_cnt), 0);
      end
    end
  endtask

  task automatic end_run(input string tag, input int steps);
    chk({tag, "_pending_events"}, expq.size(), 0);
    chk({tag, "_step_cnt"}, 32'(step_cnt), steps);
    chk({tag, "_sched_busy_end"}, 32'(sched_busy), 0);
    expq.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tik", 32'(tik), 0);
    chk("reset_step_cnt", 32'(step_cnt), 0);
    chk("reset_sched_busy", 32'(sched_busy), 0);
    chk("reset_run_done", 32'(run_done), 0);
    chk("reset_overrun", 32'(overrun), 0);
`ifdef TIK_SCHED_OVERRUN_CNT_EN
    chk("reset_overrun_cnt", 32'(overrun_cnt), 0);
`endif
    rst_n = 1'b1;

    // Cores finish well inside the period: three steps, no overrun.
    ex(1, 1); ex(2, 3); ex(1, 21); ex(2, 23); ex(1, 41); ex(2, 43); ex(3, 55);
    start_run(1, 20, 3, 2, 1'b0);
    run_for(70);
    end_run("t1", 3);

    // Core busy past the period end: overrun, then tik right after busy drops.
    ex(1, 1); ex(2, 3); ex(4, 20); ex(1, 33); ex(2, 35); ex(3, 40);
    start_run(2, 20, 2, 2, 1'b0);
    run_for(60);
    end_run("t2", 2);
`ifdef TIK_SCHED_OVERRUN_CNT_EN
    chk("t2_overrun_cnt", 32'(overrun_cnt), 1);
`endif

    // Programmed period below the minimum: eff_period = 4 + 4 + 1 = 9.
    ex(1, 1); ex(2, 5); ex(1, 10); ex(2, 14); ex(1, 19); ex(2, 23); ex(3, 28);
    start_run(3, 5, 3, 4, 1'b0);
    run_for(40);
    end_run("t3", 3);

    // Free-run, stop requested during busy step 5.
    ex(1, 1);  ex(2, 2);  ex(1, 13); ex(2, 14); ex(1, 25); ex(2, 26);
    ex(1, 37); ex(2, 38); ex(1, 49); ex(2, 50); ex(4, 60); ex(3, 71);
    start_run(4, 12, 0, 1, 1'b0);
    run_for(90);
    end_run("t4", 5);
`ifdef TIK_SCHED_OVERRUN_CNT_EN
    chk("t4_overrun_cnt_cleared", 32'(overrun_cnt), 1);
`endif

    // Reset while tik is high: tik drops, no run_done.
    ex(1, 1); ex(2, 3);
    start_run(5, 20, 0, 4, 1'b0);
    run_for(12);
    end_run("t5", 0);

    // Start and stop in the same idle cycle: the start wins and both steps run.
    ex(1, 1); ex(2, 2); ex(1, 11); ex(2, 12); ex(3, 17);
    start_run(7, 10, 2, 1, 1'b1);
    run_for(30);
    end_run("t7", 2);

    // tik_high of 0 gives a one-cycle tik; a start mid-run is ignored.
    ex(1, 1); ex(2, 2); ex(1, 11); ex(2, 12); ex(1, 21); ex(2, 22); ex(3, 27);
    start_run(6, 10, 3, 0, 1'b0);
    run_for(40);
    end_run("t6", 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
